// File: rtl/picorv32_uart_tx.sv
// picorv32_uart_tx -- memory-mapped 8N1 UART transmitter for the picorv32
// native memory bus (decoded at 0x400001xx by addr_decoder).
//
// Firmware pushes bytes into a small circular FIFO. A shift engine pops them
// and serialises each one LSB first as start bit, 8 data bits and stop bit.
// Back-to-back frames are sent with no idle gap.
//
// Register map (word offsets):
//   0x00 TXDATA  W  : push wdata[7:0] when wstrb[0]; reads return 0
//   0x01 STATUS  R  : {irq_en, busy, empty, full}; write wdata[3] -> irq_en
//   0x02 DIVISOR RW : clk cycles per bit, bytes [15:0] via wstrb[1:0], min 2
//
// Ports:
//   clk        in   single clock, rising edge
//   nrst       in   asynchronous active-low reset
//   mem_valid  in   request, already qualified by the address decoder
//   mem_ready  out  one-cycle acknowledge
//   mem_addr   in   word offset (CPU address bits [7:2])
//   mem_wdata  in   write data
//   mem_wstrb  in   byte strobes, 0 = read
//   mem_rdata  out  read data, non-zero only while mem_ready is high
//   uart_tx    out  serial output, idles high
//   tx_irq     out  only when UART_TX_IRQ_EN is defined: one-cycle pulse
//                   when the shifter goes idle with the FIFO drained
//
// Build option: define UART_TX_IRQ_EN to add tx_irq and the irq_en bit.

module picorv32_uart_tx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [5:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        tx_irq
`endif
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] DEF_DIV  = 16'(DEFAULT_DIV);
    localparam logic [15:0] MIN_DIV  = 16'd2;
    localparam logic [5:0]  A_TXDATA = 6'h00;
    localparam logic [5:0]  A_STATUS = 6'h01;
    localparam logic [5:0]  A_DIV    = 6'h02;
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]   div_q, div_d;
    logic          irq_en_q, irq_en_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic          full, empty, busy;
    logic          push, pop;
    logic          req, stall;
    logic          bit_end;
    logic [15:0]   reload;
    logic [15:0]   div_wr;
    logic [7:0]    fifo_head;
    logic          unused_bits;

    assign unused_bits = ^{mem_wdata[31:16], mem_wstrb[3:2]};

    // Full when the pointers address the same slot but are one lap apart.
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign busy      = (state_q != S_IDLE);
    assign fifo_head = fifo_mem[rd_ptr_q[AW-1:0]];

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign uart_tx   = tx_q;

    // ---------------------------------------------------------------
    // Bus slave: one-cycle ack, register access on the ack edge
    // ---------------------------------------------------------------
    assign req   = mem_valid && !ready_q;
    // A TXDATA push into a full FIFO waits; full is registered state, so a
    // pop on the same edge only frees the slot for the following cycle.
    assign stall = (mem_addr == A_TXDATA) && mem_wstrb[0] && full;

    always_comb begin
        ready_d  = 1'b0;
        rdata_d  = '0;
        push     = 1'b0;
        div_d    = div_q;
        div_wr   = div_q;
        irq_en_d = irq_en_q;
        if (req && !stall) begin
            ready_d = 1'b1;
            case (mem_addr)
                A_TXDATA: push = mem_wstrb[0];
                A_STATUS: begin
                    if (mem_wstrb == 4'd0)
                        rdata_d = {28'd0, irq_en_q, busy, empty, full};
`ifdef UART_TX_IRQ_EN
                    if (mem_wstrb[0])
                        irq_en_d = mem_wdata[3];
`endif
                end
                A_DIV: begin
                    if (mem_wstrb == 4'd0)
                        rdata_d = {16'd0, div_q};
                    if (|mem_wstrb[1:0]) begin
                        div_wr[7:0]  = mem_wstrb[0] ? mem_wdata[7:0]  : div_q[7:0];
                        div_wr[15:8] = mem_wstrb[1] ? mem_wdata[15:8] : div_q[15:8];
                        div_d        = (div_wr < MIN_DIV) ? MIN_DIV : div_wr;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Shifter FSM: next state and outputs
    // ---------------------------------------------------------------
    assign bit_end = (cnt_q == 16'd0);
    // Divisor is sampled only here, so a new value never shortens a bit.
    assign reload  = div_q - 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    tx_d    = 1'b0;
                    cnt_d   = reload;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    cnt_d   = reload;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = reload;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        tx_d    = 1'b0;
                        cnt_d   = reload;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            div_q    <= DEF_DIV;
            irq_en_q <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            div_q    <= div_d;
            irq_en_q <= irq_en_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    // Data storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (push)
            fifo_mem[wr_ptr_q[AW-1:0]] <= mem_wdata[7:0];
    end

`ifdef UART_TX_IRQ_EN
    logic irq_q, irq_d;

    // Leaving STOP without a chained pop means the FIFO is drained.
    assign irq_d  = (state_q == S_STOP) && bit_end && empty && irq_en_q;
    assign tx_irq = irq_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            irq_q <= 1'b0;
        else
            irq_q <= irq_d;
    end
`endif

endmodule
